// File: rtl/bcd_disp_pkg.sv
// ----------------------------------------------------------------------------
// bcd_disp_pkg
// Shared definitions for the BCD display controller: controller state
// encoding, BCD nibble width and the active-low seven-segment patterns
// (bit k = segment k, k=0..6 = a..g, 0 = segment lit).
// ----------------------------------------------------------------------------
package bcd_disp_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam int BCD_NIBBLE = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit patterns 0..9, entry [d] is the pattern for digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/bcd_display_ctrl_seg7_digit.sv
// ----------------------------------------------------------------------------
// seg7_digit
// Combinational BCD digit to active-low seven-segment decoder.
// Ports:
//   digit  in  4  BCD digit (10..15 decode to blank)
//   blank  in  1  force all segments off
//   seg    out 7  active-low segments, seg[k] = segment k (a..g)
// ----------------------------------------------------------------------------
module seg7_digit
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] seg_s;

    // Table lookup with blanking and out-of-range protection.
    always_comb begin
        seg_s = SEG_BLANK;
        if (blank) begin
            seg_s = SEG_BLANK;
        end else if (digit < 4'd10) begin
            seg_s = SEG_TABLE[digit];
        end else begin
            seg_s = SEG_BLANK;
        end
    end

    assign seg = seg_s;

endmodule

// File: rtl/bcd_display_ctrl.sv
// ----------------------------------------------------------------------------
// bcd_display_ctrl
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// driving one seven-segment decoder per decimal digit.
// Ports:
//   clk    in   1           system clock, rising edge
//   reset  in   1           synchronous, active-high
//   start  in   1           request conversion of v (honoured only when idle)
//   v      in   WIDTH       unsigned value, captured on the accepted start
//   busy   out  1           conversion in progress
//   done   out  1           one-cycle pulse, bcd/hex update in this cycle
//   bcd    out  4*DIGITS    registered result, digit i at bcd[4*i+:4]
//   hex    out  7*DIGITS    active-low segments, digit i at hex[7*i+:7]
// Build option:
//   BCD_BLANK_LEADING_ZEROS_EN  blank digits above the most significant
//                               nonzero digit (digit 0 always shown).
// ----------------------------------------------------------------------------
module bcd_display_ctrl
    import bcd_disp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WIDTH-1:0]             v,
    output logic                         busy,
    output logic                         done,
    output logic [BCD_NIBBLE*DIGITS-1:0] bcd,
    output logic [7*DIGITS-1:0]          hex
);

    localparam int SW = BCD_NIBBLE * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if ((WIDTH < 4) || (WIDTH > 16)) begin : g_width_check
        $error("bcd_display_ctrl: WIDTH must be 4..16");
    end
    if ((10 ** DIGITS) < (2 ** WIDTH)) begin : g_digits_check
        $error("bcd_display_ctrl: DIGITS too small for WIDTH");
    end

    state_t         state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [SW-1:0]  scratch_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;
    logic [SW-1:0]  bcd_r;

    logic [SW-2:0]  adj_s;
    logic [SW-1:0]  step_s;
    logic [DIGITS-1:0] blank_s;

    // Add-3 correction on every nibble; the top nibble's carry bit is shifted
    // out and can never be set for legal parameters, so it is not kept.
    always_comb begin
        logic [3:0] nib;
        adj_s = '0;
        nib   = 4'd0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            nib = scratch_r[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end else begin
                nib = nib;
            end
            adj_s[4*i +: 4] = nib;
        end
        nib = scratch_r[SW-4 +: 4];
        if (nib >= 4'd5) begin
            nib = nib + 4'd3;
        end else begin
            nib = nib;
        end
        adj_s[SW-4 +: 3] = nib[2:0];
        step_s = {adj_s, shreg_r[WIDTH-1]};
    end

    // Conversion sequencer: capture, WIDTH shift steps, result publish.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            shreg_r   <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            bcd_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        shreg_r   <= v;
                        scratch_r <= '0;
                        cnt_r     <= CNT_LOAD;
                        busy_r    <= 1'b1;
                        state_r   <= CONVERT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                CONVERT: begin
                    scratch_r <= step_s;
                    shreg_r   <= {shreg_r[WIDTH-2:0], 1'b0};
                    cnt_r     <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        bcd_r   <= step_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= CONVERT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Leading-zero blanking mask, derived from the registered result only.
    always_comb begin
        blank_s = '0;
`ifdef BCD_BLANK_LEADING_ZEROS_EN
        begin
            logic lead_zero;
            lead_zero = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                lead_zero  = lead_zero && (bcd_r[4*i +: 4] == 4'd0);
                blank_s[i] = lead_zero;
            end
        end
`else
        blank_s = '0;
`endif
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_digit u_seg (
            .digit (bcd_r[4*g +: 4]),
            .blank (blank_s[g]),
            .seg   (hex[7*g +: 7])
        );
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;

endmodule
